fir_out_collector: RTL and testbench



---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_out_fifo.sv | 74 +++++++
 rtl/fir_out_collector.sv | 83 ++++++++
 tb/tb_fir_out_collector.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and the narrowing helper for the FIR output path.
// Build with FIR_OUT_SAT_EN defined to saturate instead of wrap when narrowing.
package fir_pkg;

    localparam int FIR_DATA_W   = 32;
    localparam int FIR_PIPE_LAT = 13;

    // Operates at 64 bits so one function serves any DATA_W/OUT_W up to 64;
    // the caller keeps the low outW bits of the result.
    function automatic logic signed [63:0] fir_narrow(
        input logic signed [63:0] value,
        input int                 shift,
        input int                 outW
    );
        logic signed [63:0] s;
`ifdef FIR_OUT_SAT_EN
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
`endif
        s = value >>> shift;
`ifdef FIR_OUT_SAT_EN
        maxV = (64'sd1 <<< (outW - 1)) - 64'sd1;
        minV = -maxV - 64'sd1;
        if (s > maxV) begin
            s = maxV;
        end else if (s < minV) begin
            s = minV;
        end
`else
        s = (s <<< (64 - outW)) >>> (64 - outW);
`endif
        return s;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO with occupancy count; head reads as 0 when empty.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_canPush,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_valid;

    logic               w_pop;
    logic               w_push;
    logic [LEVEL_W-1:0] w_nextLevel;

    assign w_pop     = r_valid && i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign o_canPush = (r_level < LEVEL_W'(DEPTH)) || w_pop;
    assign w_push    = i_push && o_canPush;

    always_comb begin
        w_nextLevel = r_level;
        if (w_push && !w_pop) begin
            w_nextLevel = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_nextLevel = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_level <= w_nextLevel;
            r_valid <= (w_nextLevel != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    assign o_data  = r_valid ? r_mem[r_rdPtr] : '0;
    assign o_valid = r_valid;
    assign o_level = r_level;

endmodule

// File: rtl/fir_out_collector.sv
// Tags valid FIR results, decimates, narrows and buffers them for a valid/ready consumer.
// FIR_OUT_SAT_EN selects saturating rather than wrap-around narrowing.
module fir_out_collector
    import fir_pkg::*;
#(
    parameter int DATA_W   = FIR_DATA_W,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 8,
    parameter int PIPE_LAT = FIR_PIPE_LAT,
    parameter int DECIM    = 4,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        fir_data,
    output logic [OUT_W-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    input  logic                     clr_ovf,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PIPE_LAT-1:0] r_tagPipe;
    logic [DCNT_W-1:0]   r_dcnt;
    logic                r_overflow;

    logic                w_tag;
    logic                w_keep;
    logic                w_canPush;
    logic [OUT_W-1:0]    w_narrow;

    assign w_tag    = r_tagPipe[PIPE_LAT-1];
    assign w_keep   = w_tag && (r_dcnt == '0);
    assign w_narrow = OUT_W'(fir_narrow(64'($signed(fir_data)), SHIFT, OUT_W));

    // Sticky drop flag: a drop in the same cycle as clr_ovf keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tagPipe  <= '0;
            r_dcnt     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tagPipe[0] <= s_valid;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tagPipe[i] <= r_tagPipe[i-1];
            end
            if (w_tag) begin
                if (r_dcnt == DCNT_W'(DECIM - 1)) begin
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
            if (w_keep && !w_canPush) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    fir_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_keep),
        .i_data    (w_narrow),
        .i_ready   (m_ready),
        .o_data    (m_data),
        .o_valid   (m_valid),
        .o_canPush (w_canPush),
        .o_level   (level)
    );

    assign overflow = r_overflow;

endmodule

// File: tb/tb_fir_out_collector.sv
// Directed bench for fir_out_collector with default parameters (PIPE_LAT=13, DECIM=4, DEPTH=8).
module tb_fir_out_collector;

    logic        clk;
    logic        reset;
    logic        sValid;
    logic [31:0] firData;
    logic [15:0] mData;
    logic        mValid;
    logic        mReady;
    logic        clrOvf;
    logic        overflow;
    logic [3:0]  level;

    int testCount = 0;
    int failCount = 0;

    fir_out_collector dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (sValid),
        .fir_data (firData),
        .m_data   (mData),
        .m_valid  (mValid),
        .m_ready  (mReady),
        .clr_ovf  (clrOvf),
        .overflow (overflow),
        .level    (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle of inputs and returns 1 time unit after the closing edge.
    task automatic applyStimulus(input logic sv, input logic [31:0] d,
                                 input logic rdy, input logic clr);
        sValid  = sv;
        firData = d;
        mReady  = rdy;
        clrOvf  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    // One valid sample in cycle 0, its result presented in cycle 13; returns in cycle 14.
    task automatic sendOne(input logic [31:0] d);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        repeat (12) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, d, 1'b0, 1'b0);
    endtask

    logic [15:0] expPos;
    logic [15:0] expNeg;

    initial begin
`ifdef FIR_OUT_SAT_EN
        expPos = 16'h7FFF;
        expNeg = 16'h8000;
`else
        expPos = 16'hFF00;
        expNeg = 16'h0000;
`endif
        sValid  = 1'b0;
        firData = 32'h0;
        mReady  = 1'b0;
        clrOvf  = 1'b0;

        // Reset with random inputs toggling
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)),
                          1'($urandom_range(1)));
        end
        checkOutput("reset_m_valid", 32'(mValid), 32'h0);
        checkOutput("reset_m_data", 32'(mData), 32'h0);
        checkOutput("reset_overflow", 32'(overflow), 32'h0);
        checkOutput("reset_level", 32'(level), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;

        // Single sample latency and scaling
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        repeat (12) applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checkOutput("single_not_early", 32'(mValid), 32'h0);
        applyStimulus(1'b0, 32'h0001_2345, 1'b0, 1'b0);
        checkOutput("single_m_valid", 32'(mValid), 32'h1);
        checkOutput("single_m_data", 32'(mData), 32'h0123);
        checkOutput("single_level", 32'(level), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("single_pop_level", 32'(level), 32'h0);
        checkOutput("single_pop_valid", 32'(mValid), 32'h0);
        checkOutput("single_empty_data", 32'(mData), 32'h0);

        // Decimation: 8 valid samples keep indices 0 and 4
        doReset();
        for (int c = 0; c < 23; c++) begin
            applyStimulus(c < 8, (c >= 13 && c < 21) ? 32'((c - 13) << 8) : 32'h5555_0000,
                          1'b0, 1'b0);
        end
        checkOutput("decim_level", 32'(level), 32'h2);
        checkOutput("decim_first", 32'(mData), 32'h0000);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("decim_second", 32'(mData), 32'h0004);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("decim_drained", 32'(level), 32'h0);

        // Narrowing at both extremes
        doReset();
        sendOne(32'h7FFF_0000);
        checkOutput("narrow_pos", 32'(mData), 32'(expPos));
        doReset();
        sendOne(32'h8000_0000);
        checkOutput("narrow_neg_valid", 32'(mValid), 32'h1);
        checkOutput("narrow_neg", 32'(mData), 32'(expNeg));

        // Overflow: 40 samples, 10 kept, FIFO holds 8; clr_ovf coincides with first drop
        doReset();
        for (int c = 0; c < 56; c++) begin
            if (c == 45) checkOutput("ovf_before_drop", 32'(overflow), 32'h0);
            if (c == 46) checkOutput("ovf_set_wins", 32'(overflow), 32'h1);
            applyStimulus(c < 40, (c >= 13) ? 32'((c - 13) << 8) : 32'h0, 1'b0, c == 45);
        end
        checkOutput("ovf_level_full", 32'(level), 32'h8);
        checkOutput("ovf_hold_data", 32'(mData), 32'h0000);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("ovf_drain_%0d", i), 32'(mData), 32'(4 * i));
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        end
        checkOutput("ovf_drained_valid", 32'(mValid), 32'h0);
        checkOutput("ovf_still_sticky", 32'(overflow), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("ovf_cleared", 32'(overflow), 32'h0);

        // Full FIFO with a pop during the ninth push: no drop
        doReset();
        for (int c = 0; c < 46; c++) begin
            applyStimulus(c < 33, (c >= 13) ? 32'((c - 13) << 8) : 32'h0, c == 45, 1'b0);
        end
        checkOutput("full_pop_level", 32'(level), 32'h8);
        checkOutput("full_pop_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("full_drain_%0d", i), 32'(mData), 32'(4 * (i + 1)));
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        end
        checkOutput("full_drained_level", 32'(level), 32'h0);

        // Reset mid-operation with level=5 and tags in flight
        doReset();
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1'b1, (c >= 13) ? 32'((c - 13) << 8) : 32'h0, 1'b0, 1'b0);
        end
        checkOutput("mid_level_before", 32'(level), 32'h5);
        reset = 1'b0;
        #1;
        checkOutput("mid_async_level", 32'(level), 32'h0);
        applyStimulus(1'b0, 32'h1234_5678, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h1234_5678, 1'b0, 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 32'h1234_5678, 1'b1, 1'b0);
            checkOutput($sformatf("mid_valid_%0d", c), 32'(mValid), 32'h0);
        end
        checkOutput("mid_level_after", 32'(level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
